// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: generates the PDM clock, samples the 1-bit stream,
// decimates it with a 3rd-order CIC filter and delivers signed 8-bit PCM
// samples on a valid/ready handshake.
// Optional build macro PDM_CIC_DCBLOCK_EN inserts a first-order DC-blocking
// high-pass between the comb output and the scaling stage (adds one clock).
module pdm_cic_decimator #(
    parameter int CLK_DIV  = 16,
    parameter int DEC_LOG2 = 6
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pdm,
    output logic       pdm_clk_out,
    output logic [7:0] sample_data,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic       overrun
);

    localparam int W     = 2 + 3 * DEC_LOG2;
    localparam int SW    = W + 2;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int SHIFT = 3 * DEC_LOG2 - 7;

    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]    DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);
    localparam logic [DEC_LOG2-1:0] DEC_ONE  = DEC_LOG2'(1);
    localparam logic signed [SW-1:0] SAT_MAX = SW'(127);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-128);

    typedef enum logic {EMPTY, FULL} state_t;

    logic [DIV_W-1:0]    divCnt_q, divCnt_d;
    logic                pdmClk_q;
    logic                sync1_q, sync2_q;
    logic                tick;
    logic signed [W-1:0] pdmVal;
    logic signed [W-1:0] int1_q, int2_q, int3_q;
    logic [DEC_LOG2-1:0] decCnt_q;
    logic                decLast;
    logic signed [W-1:0] latch_q, latchPrev_q;
    logic signed [W-1:0] comb1_q, comb1Prev_q;
    logic signed [W-1:0] comb2_q, comb2Prev_q;
    logic signed [W-1:0] comb3_q;
    logic                latchValid_q, comb1Valid_q, comb2Valid_q, comb3Valid_q;
    logic [1:0]          warmCnt_q;
    logic                resultStrobe;
    logic                newResult;
    logic signed [SW-1:0] scaleIn;
    logic signed [SW-1:0] shifted;
    logic [7:0]          scaled;
    state_t              state_q;
    logic [7:0]          data_q;
    logic                valid_q;
    logic                overrun_q;

    // Next value of the PDM bit-period counter, wrapping at CLK_DIV-1
    always_comb begin
        divCnt_d = (divCnt_q == DIV_LAST) ? '0 : divCnt_q + DIV_ONE;
    end

    assign tick = (divCnt_q == DIV_LAST);

    // Divider counter and registered PDM clock (high in the upper half of the period)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            divCnt_q <= '0;
            pdmClk_q <= 1'b0;
        end else begin
            divCnt_q <= divCnt_d;
            pdmClk_q <= (divCnt_d >= DIV_HALF);
        end
    end

    // Two-flop synchronizer for the asynchronous microphone data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pdm;
            sync2_q <= sync1_q;
        end
    end

    assign pdmVal  = sync2_q ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
    assign decLast = (decCnt_q == {DEC_LOG2{1'b1}});

    // Integrator cascade, decimation counter and decimation latch, all on the sample tick
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            int1_q       <= '0;
            int2_q       <= '0;
            int3_q       <= '0;
            decCnt_q     <= '0;
            latch_q      <= '0;
            latchValid_q <= 1'b0;
        end else begin
            latchValid_q <= 1'b0;
            if (tick) begin
                int1_q   <= int1_q + pdmVal;
                int2_q   <= int2_q + int1_q;
                int3_q   <= int3_q + int2_q;
                decCnt_q <= decCnt_q + DEC_ONE;
                if (decLast) begin
                    latch_q      <= int3_q;
                    latchValid_q <= 1'b1;
                end
            end
        end
    end

    // Comb cascade: one differentiator stage per clock following the latch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            latchPrev_q  <= '0;
            comb1_q      <= '0;
            comb1Prev_q  <= '0;
            comb2_q      <= '0;
            comb2Prev_q  <= '0;
            comb3_q      <= '0;
            comb1Valid_q <= 1'b0;
            comb2Valid_q <= 1'b0;
            comb3Valid_q <= 1'b0;
        end else begin
            comb1Valid_q <= latchValid_q;
            comb2Valid_q <= comb1Valid_q;
            comb3Valid_q <= comb2Valid_q;
            if (latchValid_q) begin
                comb1_q     <= latch_q - latchPrev_q;
                latchPrev_q <= latch_q;
            end
            if (comb1Valid_q) begin
                comb2_q     <= comb1_q - comb1Prev_q;
                comb1Prev_q <= comb1_q;
            end
            if (comb2Valid_q) begin
                comb3_q     <= comb2_q - comb2Prev_q;
                comb2Prev_q <= comb2_q;
            end
        end
    end

`ifdef PDM_CIC_DCBLOCK_EN
    logic signed [SW-1:0] dcIn;
    logic signed [SW-1:0] dcPrevIn_q;
    logic signed [SW-1:0] dcOut_q;
    logic                 dcValid_q;

    assign dcIn = {{2{comb3_q[W-1]}}, comb3_q};

    // DC-blocking high-pass: y = x - x_prev + y_prev - y_prev/256
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dcPrevIn_q <= '0;
            dcOut_q    <= '0;
            dcValid_q  <= 1'b0;
        end else begin
            dcValid_q <= comb3Valid_q;
            if (comb3Valid_q) begin
                dcOut_q    <= dcIn - dcPrevIn_q + dcOut_q - (dcOut_q >>> 8);
                dcPrevIn_q <= dcIn;
            end
        end
    end

    assign scaleIn      = dcOut_q;
    assign resultStrobe = dcValid_q;
`else
    assign scaleIn      = {{2{comb3_q[W-1]}}, comb3_q};
    assign resultStrobe = comb3Valid_q;
`endif

    // Scale the filter output to 8 bits and saturate to the signed byte range
    always_comb begin
        shifted = scaleIn >>> SHIFT;
        if (shifted > SAT_MAX) begin
            scaled = 8'h7F;
        end else if (shifted < SAT_MIN) begin
            scaled = 8'h80;
        end else begin
            scaled = shifted[7:0];
        end
    end

    // Warm-up counter: the first three filter results carry start-up transients
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            warmCnt_q <= 2'd0;
        end else if (resultStrobe && (warmCnt_q != 2'd3)) begin
            warmCnt_q <= warmCnt_q + 2'd1;
        end
    end

    assign newResult = resultStrobe && (warmCnt_q == 2'd3);

    // Output holding register: EMPTY/FULL handshake with sticky overrun on drop
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (newResult) begin
                        data_q  <= scaled;
                        valid_q <= 1'b1;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (sample_ready) begin
                        if (newResult) begin
                            data_q <= scaled;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= EMPTY;
                        end
                    end else if (newResult) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pdm_clk_out  = pdmClk_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed testbench for pdm_cic_decimator at default parameters:
// clock divider shape, saturated full-scale inputs, alternating input,
// overrun handling and asynchronous reset while a sample is pending.
module tb_pdm_cic_decimator;

    logic       clock;
    logic       reset_n;
    logic       pdm;
    logic       pdm_clk_out;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic       sample_ready;
    logic       overrun;

    int checkCnt;
    int errorCnt;
    int altCnt;
    bit altMode;

    pdm_cic_decimator #(
        .CLK_DIV (16),
        .DEC_LOG2(6)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pdm         (pdm),
        .pdm_clk_out (pdm_clk_out),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun)
    );

    // 100 MHz-style free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog so the run always ends even if the design stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCnt++;
        if (observed !== expected) begin
            errorCnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock, sample point 1 time unit after the rising edge;
    // in alternating mode the PDM bit flips once per 16-clock bit period
    task automatic stepClock();
        @(posedge clock);
        #1;
        altCnt++;
        if (altMode && (altCnt % 16 == 0)) begin
            pdm = ~pdm;
        end
    endtask

    // Reset the design and then apply a PDM pattern and ready level
    task automatic applyStimulus(input bit pdmLevel, input bit alt, input bit ready);
        reset_n      = 1'b0;
        pdm          = pdmLevel;
        altMode      = 1'b0;
        sample_ready = ready;
        stepClock();
        stepClock();
        altCnt  = 0;
        altMode = alt;
        reset_n = 1'b1;
    endtask

    // Wait for sample_valid, bounded by a cycle budget
    task automatic waitValid(input int budget, output int steps, output bit ok);
        ok    = 1'b0;
        steps = 0;
        while (steps < budget) begin
            stepClock();
            steps++;
            if (sample_valid) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Run a number of cycles and count how many show sample_valid high
    task automatic countValid(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            stepClock();
            if (sample_valid) cnt++;
        end
    endtask

    initial begin
        int  highs;
        int  lastRise;
        int  period;
        int  runStart;
        int  runLen;
        int  vcnt;
        int  steps;
        bit  ok;
        bit  prev;

        checkCnt     = 0;
        errorCnt     = 0;
        altCnt       = 0;
        altMode      = 1'b0;
        pdm          = 1'b0;
        sample_ready = 1'b0;
        reset_n      = 1'b0;
        #3;
        checkOutput("reset_pdm_clk", {31'd0, pdm_clk_out}, 32'd0);
        checkOutput("reset_data", {24'd0, sample_data}, 32'd0);
        checkOutput("reset_valid", {31'd0, sample_valid}, 32'd0);
        checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);

        // Divider shape over 64 clocks after reset release
        applyStimulus(1'b0, 1'b0, 1'b1);
        highs    = 0;
        lastRise = -1;
        period   = 0;
        runStart = 0;
        runLen   = 0;
        vcnt     = 0;
        prev     = pdm_clk_out;
        for (int i = 0; i < 64; i++) begin
            stepClock();
            if (pdm_clk_out) highs++;
            if (sample_valid) vcnt++;
            if (pdm_clk_out && !prev) begin
                if (lastRise >= 0) period = i - lastRise;
                lastRise = i;
                runStart = i;
            end
            if (!pdm_clk_out && prev) runLen = i - runStart;
            prev = pdm_clk_out;
        end
        checkOutput("div_high_count", highs, 32);
        checkOutput("div_period", period, 16);
        checkOutput("div_high_len", runLen, 8);
        checkOutput("div_no_valid", vcnt, 0);

        // Constant 1: warm-up, then +full scale saturates to 0x7F every 1024 clocks
        applyStimulus(1'b1, 1'b0, 1'b1);
        countValid(3172, vcnt);
        checkOutput("ones_warmup_no_valid", vcnt, 0);
        waitValid(1100, steps, ok);
        checkOutput("ones_first_valid_seen", {31'd0, ok}, 32'd1);
        checkOutput("ones_first_data", {24'd0, sample_data}, 32'h7F);
        stepClock();
        checkOutput("ones_valid_width", {31'd0, sample_valid}, 32'd0);
        waitValid(1100, steps, ok);
        checkOutput("ones_second_valid_seen", {31'd0, ok}, 32'd1);
        checkOutput("ones_interval", steps + 1, 1024);
        checkOutput("ones_second_data", {24'd0, sample_data}, 32'h7F);

        // Constant 0: -full scale saturates to 0x80
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitValid(4300, steps, ok);
        checkOutput("zeros_first_valid_seen", {31'd0, ok}, 32'd1);
        checkOutput("zeros_first_data", {24'd0, sample_data}, 32'h80);
        stepClock();
        waitValid(1100, steps, ok);
        checkOutput("zeros_second_data", {24'd0, sample_data}, 32'h80);

        // Alternating bits: zero mean gives exactly zero output
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitValid(4300, steps, ok);
        checkOutput("alt_first_valid_seen", {31'd0, ok}, 32'd1);
        checkOutput("alt_first_data", {24'd0, sample_data}, 32'h00);
        stepClock();
        waitValid(1100, steps, ok);
        checkOutput("alt_second_data", {24'd0, sample_data}, 32'h00);

        // Downstream stalled: the held sample survives, next result sets overrun
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitValid(4300, steps, ok);
        checkOutput("ovr_first_valid_seen", {31'd0, ok}, 32'd1);
        checkOutput("ovr_first_data", {24'd0, sample_data}, 32'h7F);
        checkOutput("ovr_not_yet", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 1030; i++) stepClock();
        checkOutput("ovr_valid_held", {31'd0, sample_valid}, 32'd1);
        checkOutput("ovr_flag_set", {31'd0, overrun}, 32'd1);
        checkOutput("ovr_data_held", {24'd0, sample_data}, 32'h7F);
        sample_ready = 1'b1;
        stepClock();
        sample_ready = 1'b0;
        checkOutput("ovr_valid_dropped", {31'd0, sample_valid}, 32'd0);
        checkOutput("ovr_flag_sticky", {31'd0, overrun}, 32'd1);

        // Reset asserted while a sample is pending clears outputs immediately
        waitValid(1100, steps, ok);
        checkOutput("rst_full_before", {31'd0, ok}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", {31'd0, sample_valid}, 32'd0);
        checkOutput("rst_mid_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("rst_mid_pdm_clk", {31'd0, pdm_clk_out}, 32'd0);
        checkOutput("rst_mid_data", {24'd0, sample_data}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        countValid(3172, vcnt);
        checkOutput("rst_warmup_no_valid", vcnt, 0);
        waitValid(1100, steps, ok);
        checkOutput("rst_valid_after_warmup", {31'd0, ok}, 32'd1);
        checkOutput("rst_data_after_warmup", {24'd0, sample_data}, 32'h7F);

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errorCnt);
        $finish;
    end

endmodule

// File: doc/pdm_cic_decimator.md
Name: pdm_cic_decimator

Overview:
- Front end of the MEMS microphone path, directly upstream of the Avalon on-chip-memory writer.
- Generates the PDM microphone clock and samples the 1-bit PDM stream.
- Decimates the stream with a 3rd-order CIC filter and presents signed 8-bit PCM samples on a valid/ready handshake.
- The writer consumes each accepted sample as one byte write.

Parameters:
- CLK_DIV, 16: clock cycles per PDM bit period. Even, ≥4. 50 MHz / 16 = 3.125 MHz PDM clock.
- DEC_LOG2, 6: log2 of the decimation ratio R. R = 64. Legal range 3..10.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- pdm  in  1  raw PDM data from the microphone (asynchronous to clock)
- pdm_clk_out  out  1  PDM clock to the microphone
- sample_data  out  8  signed two's-complement PCM sample
- sample_valid  out  1  sample_data holds an unconsumed sample
- sample_ready  in  1  downstream accepts the sample this cycle
- overrun  out  1  sticky flag: a sample was dropped

Behaviour:
- Reset: one clock, asynchronous active-low reset (reset_n). Reset mid-operation clears everything immediately, including a pending sample.
- Reset values: pdm_clk_out=0, sample_data=0, sample_valid=0, overrun=0. Divider, integrators, combs, decimation counter and warm-up counter all reset to 0.
- Clock divider: counter div_cnt runs 0..CLK_DIV-1 and wraps.
  - pdm_clk_out is registered: high when div_cnt ≥ CLK_DIV/2, low otherwise.
- PDM input path: pdm passes through a 2-flop synchronizer.
  - Sample tick = the cycle with div_cnt==CLK_DIV-1, i.e. the end of the high phase.
  - On the tick, the synchronized bit maps to +1 (bit 1) or -1 (bit 0).
- Internal width: W = 2 + 3*DEC_LOG2 (20 bits at default). All arithmetic is signed and wraps modulo 2^W; wrap is intentional for a CIC.
- Integrators: three cascaded accumulators, updated once per sample tick. Each adds the previous stage's registered value, so the integrator pipeline is 1 tick per stage.
- Decimation: counter dec_cnt counts sample ticks 0..R-1. On the tick where dec_cnt==R-1, the last integrator output is latched.
- Combs: three cascaded differentiators with M=1, each y = x - x_prev.
  - They update in consecutive clock cycles after the latch, one stage per cycle.
  - The result is ready 3 clocks after the latch.
- Scaling: out = comb3 arithmetically shifted right by 3*DEC_LOG2-7, then saturated to [-128, 127].
  - Full scale ±2^(3*DEC_LOG2) therefore maps to +127 / -128.
- Warm-up: the first 3 decimated results after reset are discarded and never reach the output.
- Output FSM, states EMPTY and FULL:
  - EMPTY: a new result loads sample_data and sets sample_valid=1 on the next clock → FULL.
  - FULL: sample_valid && sample_ready with no new result → sample_valid=0 → EMPTY.
  - FULL, with handshake and new result in the same cycle: the new result loads and sample_valid stays 1.
  - FULL, new result without handshake: the new result is dropped, sample_data is held, overrun=1 until reset.
  - sample_data is stable while sample_valid && !sample_ready.
- Latency: synchronized PDM bit → first use in integrator 1 at the next tick. Decimation latch → sample_valid: 4 clocks (3 comb cycles + output register).

Optional Feature:
- Macro: PDM_CIC_DCBLOCK_EN.
- Defined: a first-order DC-blocking high-pass is inserted between the comb output and scaling.
  - y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 8).
  - W+2 bits wide, state reset to 0.
  - Adds 1 clock of latency, so decimation latch → valid is 5 clocks.
  - A constant input decays toward 0.
- Not defined: there is no high-pass stage, and latency is 4 clocks as above.

Test Plan (defaults, macro undefined):
- Reset release, then observe 64 clocks → pdm_clk_out toggles with period 16 clocks and 50% duty (high 8, low 8); sample_valid stays 0.
- pdm held 1, sample_ready=1 → no valid for the first 3 decimations; every later sample = 0x7F (+2^18 saturates), one valid pulse every 1024 clocks.
- pdm held 0, sample_ready=1 → steady-state samples = 0x80 (-128).
- pdm alternating 1,0 on successive ticks → steady-state samples = 0x00.
- pdm held 1, sample_ready=0 → first sample 0x7F stays valid; at the next decimation overrun=1 and data stays 0x7F. Raise sample_ready for 1 cycle → valid drops; overrun stays 1.
- reset_n pulsed low while FULL → sample_valid, overrun and pdm_clk_out are 0 in the same cycle. After release, 3 warm-up decimations occur again before the next valid.
